// File: rtl/slv_guard_rst_ctrl.sv
// Sequences isolate -> reset -> settle on the guarded subordinate and reports completion.
// Optional SLV_GUARD_RST_CTRL_IRQ_RST_EN lets irq_i trigger a sequence as well.
module slv_guard_rst_ctrl #(
    parameter int IsoCycles    = 4,
    parameter int HoldCycles   = 16,
    parameter int SettleCycles = 8,
    parameter int MaxResets    = 3,
    parameter int CntWidth     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rst_req_i,
    input  logic                irq_i,
    input  logic                sw_clear_i,
    output logic                slv_rst_no,
    output logic                isolate_o,
    output logic                rst_stat_o,
    output logic                busy_o,
    output logic                lockout_o,
    output logic [CntWidth-1:0] rst_cnt_o
);

    typedef enum logic [2:0] {IDLE, ISO, ASSERT, SETTLE, DONE, WAIT} state_t;

    localparam logic [CntWidth-1:0] ISO_LD    = CntWidth'(IsoCycles - 1);
    localparam logic [CntWidth-1:0] HOLD_LD   = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] SETTLE_LD = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] MAX_RST   = CntWidth'(MaxResets);
    localparam logic [CntWidth-1:0] CNT_MAX   = '1;

    state_t              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] rst_cnt_inc;
    logic                trig;

`ifdef SLV_GUARD_RST_CTRL_IRQ_RST_EN
    assign trig = rst_req_i | irq_i;
`else
    logic unused_irq;
    assign unused_irq = irq_i;
    assign trig       = rst_req_i;
`endif

    assign rst_cnt_inc = (rst_cnt_o == CNT_MAX) ? rst_cnt_o : rst_cnt_o + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (trig && !lockout_o) begin
                    state_d = ISO;
                    cnt_d   = ISO_LD;
                end
            end
            ISO: begin
                if (cnt_q == '0) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            // A request already gone by DONE needs no WAIT cycle to debounce.
            DONE:    state_d = trig ? WAIT : IDLE;
            WAIT:    if (!trig) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state itself.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            slv_rst_no <= 1'b0;
            isolate_o  <= 1'b0;
            rst_stat_o <= 1'b0;
            busy_o     <= 1'b0;
            lockout_o  <= 1'b0;
            rst_cnt_o  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slv_rst_no <= (state_d != ASSERT);
            isolate_o  <= (state_d inside {ISO, ASSERT, SETTLE});
            rst_stat_o <= (state_d == DONE);
            busy_o     <= (state_d != IDLE);
            if (sw_clear_i) begin
                rst_cnt_o <= '0;
                lockout_o <= 1'b0;
            end else if (state_d == DONE) begin
                rst_cnt_o <= rst_cnt_inc;
                if (MaxResets != 0 && rst_cnt_inc >= MAX_RST) lockout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Randomized scoreboard bench for slv_guard_rst_ctrl: driver predicts each reset sequence,
// monitor checks every output edge against the predicted timeline.
module tb_slv_guard_rst_ctrl;

    localparam int ISO = 4, HOLD = 16, SETTLE = 8, MAXR = 3, CW = 8;
    localparam int DONE_OFS = ISO + HOLD + SETTLE + 1;

`ifdef SLV_GUARD_RST_CTRL_IRQ_RST_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rst_req_i = 1'b0;
    logic          irq_i = 1'b0;
    logic          sw_clear_i = 1'b0;
    logic          slv_rst_no, isolate_o, rst_stat_o, busy_o, lockout_o;
    logic [CW-1:0] rst_cnt_o;

    slv_guard_rst_ctrl #(
        .IsoCycles(ISO), .HoldCycles(HOLD), .SettleCycles(SETTLE),
        .MaxResets(MAXR), .CntWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rst_req_i(rst_req_i), .irq_i(irq_i),
        .sw_clear_i(sw_clear_i), .slv_rst_no(slv_rst_no), .isolate_o(isolate_o),
        .rst_stat_o(rst_stat_o), .busy_o(busy_o), .lockout_o(lockout_o),
        .rst_cnt_o(rst_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    typedef struct {
        int k;      // cycle the trigger was presented in IDLE
        int bend;   // cycle busy_o is first seen low again
        int cnt;
        int lock;
    } exp_t;
    exp_t q[$];

    // Reference state: consecutive completed sequences and lockout, by the rules alone.
    int m_cnt = 0;
    bit m_lock = 1'b0;
    bit mon_en = 1'b0;

    // Monitor: any output edge must belong to the sequence at the head of the queue.
    logic iso_q = 1'b0, slv_q = 1'b0, busy_q = 1'b0;
    always @(negedge clk_i) begin
        exp_t e;
        if (mon_en && (isolate_o != iso_q || slv_rst_no != slv_q || busy_o != busy_q || rst_stat_o)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_activity at cycle %0d: iso=%0b rst_n=%0b busy=%0b stat=%0b",
                         cyc, isolate_o, slv_rst_no, busy_o, rst_stat_o);
            end else begin
                e = q[0];
                if (busy_o && !busy_q)     chk("busy_rise", cyc, e.k + 1);
                if (isolate_o && !iso_q)   chk("iso_rise", cyc, e.k + 1);
                if (!isolate_o && iso_q)   chk("iso_fall", cyc, e.k + DONE_OFS);
                if (!slv_rst_no && slv_q)  chk("rst_fall", cyc, e.k + 1 + ISO);
                if (slv_rst_no && !slv_q)  chk("rst_rise", cyc, e.k + 1 + ISO + HOLD);
                if (rst_stat_o) begin
                    chk("stat_time", cyc, e.k + DONE_OFS);
                    chk("stat_cnt", int'(rst_cnt_o), e.cnt);
                    chk("stat_lock", int'(lockout_o), e.lock);
                end
                if (!busy_o && busy_q) begin
                    chk("busy_fall", cyc, e.bend);
                    void'(q.pop_front());
                end
            end
        end
        iso_q  = isolate_o;
        slv_q  = slv_rst_no;
        busy_q = busy_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One trigger of length len from rst_req_i (src=0) or irq_i (src=1).
    // clr_mode: 0 none, 1 clear mid-sequence, 2 clear on the edge that completes it.
    task automatic run_txn(input int len, input int clr_mode, input bit pre_clr, input bit src);
        int k, span, c;
        bit acc, l;
        exp_t e;
        if (pre_clr) begin
            sw_clear_i = 1'b1;
            step();
            sw_clear_i = 1'b0;
            m_cnt  = 0;
            m_lock = 1'b0;
        end
        k   = cyc;
        acc = (src == 1'b0 || IRQ_EN) && !m_lock;
        if (acc) begin
            c = (clr_mode == 1) ? 0 : m_cnt;
            c = (c + 1 > 255) ? 255 : c + 1;
            l = (MAXR != 0) && (c >= MAXR);
            if (clr_mode == 2) begin
                c = 0;
                l = 1'b0;
            end
            m_cnt  = c;
            m_lock = l;
            e.k    = k;
            e.bend = (k + len + 1 > k + DONE_OFS + 1) ? k + len + 1 : k + DONE_OFS + 1;
            e.cnt  = c;
            e.lock = l;
            q.push_back(e);
        end
        span = ((len > DONE_OFS + 2) ? len : DONE_OFS + 2) + 2;
        for (int i = 0; i < span; i++) begin
            if (src) irq_i = (i < len);
            else     rst_req_i = (i < len);
            sw_clear_i = acc && ((clr_mode == 1 && i == 10) || (clr_mode == 2 && i == DONE_OFS - 1));
            step();
        end
        rst_req_i  = 1'b0;
        irq_i      = 1'b0;
        sw_clear_i = 1'b0;
        repeat ($urandom_range(0, 3)) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, k;
        repeat (3) step();
        chk("rst_slv_rst_n", int'(slv_rst_no), 0);
        chk("rst_isolate", int'(isolate_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_lockout", int'(lockout_o), 0);
        chk("rst_cnt", int'(rst_cnt_o), 0);
        rst_ni = 1'b1;
        step();
        chk("rel_slv_rst_n", int'(slv_rst_no), 1);
        step();
        mon_en = 1'b1;

        // Pulse, long hold, third completes into lockout, locked request, then clear and rerun.
        run_txn(1, 0, 1'b0, 1'b0);
        run_txn(100, 0, 1'b0, 1'b0);
        run_txn(5, 0, 1'b0, 1'b0);
        chk("lockout_set", int'(lockout_o), 1);
        chk("cnt_at_lock", int'(rst_cnt_o), 3);
        run_txn(8, 0, 1'b0, 1'b0);
        run_txn(3, 0, 1'b1, 1'b0);
        chk("cnt_after_clear", int'(rst_cnt_o), 1);

        // Clear coinciding with the third completion wins.
        run_txn(2, 0, 1'b1, 1'b0);
        run_txn(2, 0, 1'b0, 1'b0);
        run_txn(40, 2, 1'b0, 1'b0);
        chk("coinc_lockout", int'(lockout_o), 0);
        chk("coinc_cnt", int'(rst_cnt_o), 0);

        // Interrupt alone.
        run_txn(6, 0, 1'b1, 1'b1);

        for (int n = 0; n < 30; n++) begin
            len = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(1, 40);
            run_txn(len, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset during the hold phase.
        run_txn(1, 0, 1'b1, 1'b0);
        void'(q.pop_back());
        mon_en = 1'b0;
        k = cyc;
        rst_req_i = 1'b1;
        step();
        rst_req_i = 1'b0;
        while (cyc < k + ISO + 6) step();
        chk("mid_hold_rst_n", int'(slv_rst_no), 0);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_slv_rst_n", int'(slv_rst_no), 0);
        chk("arst_isolate", int'(isolate_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_cnt", int'(rst_cnt_o), 0);
        step();
        step();
        rst_ni = 1'b1;
        step();
        chk("arel_slv_rst_n", int'(slv_rst_no), 1);
        chk("arel_busy", int'(busy_o), 0);
        chk("arel_isolate", int'(isolate_o), 0);
        q.delete();
        m_cnt  = 0;
        m_lock = 1'b0;
        step();
        mon_en = 1'b1;
        run_txn(4, 0, 1'b0, 1'b0);
        chk("post_arst_cnt", int'(rst_cnt_o), 1);

        repeat (3) step();
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
